sonar_chan_arb: RTL and testbench

SONAR_CHAN_ARB -- requirements
Module: sonar_chan_arb

---
 rtl/sonar_chan_arb.sv | 146 ++++++++++++++
 tb/tb_sonar_chan_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_chan_arb.sv
// Round-robin channel arbiter for sonar sample streams: locks one channel for a
// full FRAME_LEN-beat frame and forwards it through a single registered AXI-Stream stage.
module sonar_chan_arb #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned FRAME_LEN = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NCH*DATA_W-1:0]   s_tdata,
  input  logic [NCH-1:0]          s_tvalid,
  output logic [NCH-1:0]          s_tready,
  input  logic [NCH-1:0]          ch_en,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [$clog2(NCH)-1:0]  m_tuser,
  output logic                    m_tlast,
  output logic [$clog2(NCH)-1:0]  grant_ch,
  output logic                    busy
);

  localparam int unsigned CH_W  = $clog2(NCH);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]  RR_RST    = CH_W'(NCH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  m_tdata_q, m_tdata_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [CH_W-1:0]    m_tuser_q, m_tuser_d;
  logic               m_tlast_q, m_tlast_d;
  logic               busy_q, busy_d;

  logic [NCH-1:0]     elig_c;
  logic [2*NCH-1:0]   dbl_c;
  logic [NCH-1:0]     rot_c;
  logic               pick_vld_c;
  logic [CH_W-1:0]    pick_idx_c;
  int                 off_c;
  int                 sum_c;
  logic [NCH-1:0]     s_tready_c;
  logic               accept_c;

  // Rotate the eligible mask so bit 0 is the channel after the last grant, then take the lowest set bit.
  always_comb begin
    elig_c     = s_tvalid & ch_en;
    dbl_c      = {elig_c, elig_c} >> (int'(rr_q) + 1);
    rot_c      = dbl_c[NCH-1:0];
    pick_vld_c = |rot_c;
    off_c      = 0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = i;
    end
    sum_c = int'(rr_q) + 1 + off_c;
    if (sum_c >= int'(NCH)) sum_c = sum_c - int'(NCH);
    pick_idx_c = CH_W'(sum_c);
  end

  // Next-state, beat counter and output-stage update.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    s_tready_c = '0;
    accept_c   = 1'b0;

    if (m_tvalid_q && m_tready) m_tvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          grant_d = pick_idx_c;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        s_tready_c[grant_q] = !m_tvalid_q || m_tready;
        accept_c            = s_tvalid[grant_q] && s_tready_c[grant_q];
        if (accept_c) begin
          m_tdata_d  = s_tdata[int'(grant_q)*int'(DATA_W) +: DATA_W];
          m_tvalid_d = 1'b1;
          m_tuser_d  = grant_q;
          m_tlast_d  = (cnt_q == LAST_BEAT);
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            rr_d    = grant_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BURST);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= RR_RST;
      cnt_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      busy_q     <= busy_d;
    end
  end

  assign s_tready = s_tready_c;
  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tuser  = m_tuser_q;
  assign m_tlast  = m_tlast_q;
  assign grant_ch = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sonar_chan_arb.sv
// Scoreboard bench for sonar_chan_arb: per-channel counting sources, expected beats
// queued per scenario, and output beats popped and compared as they leave.
module tb_sonar_chan_arb;

  localparam int unsigned NCH    = 4;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned FLEN   = 10;

  logic                  clk;
  logic                  rstn;
  logic [NCH*DATA_W-1:0] s_tdata;
  logic [NCH-1:0]        s_tvalid;
  logic [NCH-1:0]        s_tready;
  logic [NCH-1:0]        ch_en;
  logic [DATA_W-1:0]     m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [1:0]            m_tuser;
  logic                  m_tlast;
  logic [1:0]            grant_ch;
  logic                  busy;

  sonar_chan_arb #(.NCH(NCH), .DATA_W(DATA_W), .FRAME_LEN(FLEN)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .ch_en    (ch_en),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast),
    .grant_ch (grant_ch),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [23:0] data;
    logic        last;
    logic        first;
  } exp_t;

  exp_t        q[$];
  int          n_chk;
  int          n_err;
  int          beat[NCH];
  int          lim[NCH];
  logic [NCH-1:0] src_on;
  bit          rnd_rdy;
  bit          mon_en;
  int          cyc_n;
  int          rise_cyc;
  bit          rise_pending;
  int          last_cyc;
  bit          last_vld;
  bit          stall_prev;
  logic [27:0] hold_prev;
  bit          watch02;
  bit          bad_rdy02;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [23:0] smp(input int k, input int n);
    return {8'(k), 16'(n)};
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < int'(NCH); k++) begin
      s_tvalid[k] = src_on[k] && (beat[k] < lim[k]);
      s_tdata[k*int'(DATA_W) +: DATA_W] = smp(k, beat[k]);
    end
  endtask

  task automatic push_frame(input int ch, input int start);
    exp_t e;
    for (int b = 0; b < int'(FLEN); b++) begin
      e.ch    = 2'(ch);
      e.data  = smp(ch, start + b);
      e.last  = (b == int'(FLEN) - 1);
      e.first = (b == 0);
      q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    chk("rdy_onehot", 64'($countones(s_tready) <= 1), 64'(1));
    if (watch02 && (s_tready[0] || s_tready[2])) bad_rdy02 = 1'b1;
    if (stall_prev) chk("hold", 64'({m_tvalid, m_tdata, m_tuser, m_tlast}), 64'(hold_prev));
    if (m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        chk("extra_beat", 64'(m_tvalid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("data", 64'(m_tdata), 64'(e.data));
        chk("tuser", 64'(m_tuser), 64'(e.ch));
        chk("tlast", 64'(m_tlast), 64'(e.last));
        if (!e.last) begin
          chk("busy", 64'(busy), 64'(1));
          chk("grant", 64'(grant_ch), 64'(e.ch));
        end
        if (e.first && rise_pending) begin
          chk("first_lat", 64'(cyc_n - rise_cyc), 64'(2));
          rise_pending = 1'b0;
        end
        if (e.first && last_vld && !rnd_rdy) chk("gap", 64'(cyc_n - last_cyc), 64'(2));
        if (e.last) begin
          last_cyc = cyc_n;
          last_vld = 1'b1;
        end
      end
    end
    stall_prev = m_tvalid && !m_tready;
    hold_prev  = {m_tvalid, m_tdata, m_tuser, m_tlast};
  endtask

  // One clock: observe at the falling edge, update sources just after the rising edge.
  task automatic cyc();
    logic [NCH-1:0] acc;
    logic           rst_seen;
    @(negedge clk);
    cyc_n++;
    acc      = s_tvalid & s_tready;
    rst_seen = rstn;
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    if (rst_seen) begin
      for (int k = 0; k < int'(NCH); k++) if (acc[k]) beat[k]++;
    end
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_inputs();
  endtask

  task automatic start_scn();
    rstn    = 1'b0;
    src_on  = '0;
    ch_en   = '1;
    rnd_rdy = 1'b0;
    m_tready = 1'b1;
    watch02 = 1'b0;
    for (int k = 0; k < int'(NCH); k++) begin
      beat[k] = 0;
      lim[k]  = 0;
    end
    drive_inputs();
    cyc();
    cyc();
    chk("rst_mvalid", 64'(m_tvalid), 64'(0));
    chk("rst_mdata", 64'(m_tdata), 64'(0));
    chk("rst_tuser", 64'(m_tuser), 64'(0));
    chk("rst_tlast", 64'(m_tlast), 64'(0));
    chk("rst_grant", 64'(grant_ch), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sready", 64'(s_tready), 64'(0));
    rstn = 1'b1;
    q.delete();
    last_vld     = 1'b0;
    stall_prev   = 1'b0;
    rise_pending = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (q.size() > 0 && t < budget) begin
      cyc();
      t++;
    end
    chk("drain_left", 64'(q.size()), 64'(0));
    repeat (15) cyc();
  endtask

  task automatic wait_beat(input int ch, input int n);
    int t;
    t = 0;
    while (beat[ch] < n && t < 200) begin
      cyc();
      t++;
    end
    chk("wait_beat", 64'(beat[ch]), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc_n = 0; mon_en = 1'b0; bad_rdy02 = 1'b0;
    s_tdata = '0; s_tvalid = '0;
    start_scn();
    mon_en = 1'b1;

    // Single channel frame and first-beat latency.
    src_on[0] = 1'b1; lim[0] = 10;
    push_frame(0, 0);
    drive_inputs();
    rise_cyc = cyc_n + 1;
    rise_pending = 1'b1;
    drain(100);
    chk("lat_seen", 64'(rise_pending), 64'(0));

    // All channels valid: round-robin 0,1,2,3,0 with one-cycle gaps.
    start_scn();
    src_on = '1; lim[0] = 20; lim[1] = 10; lim[2] = 10; lim[3] = 10;
    push_frame(0, 0); push_frame(1, 0); push_frame(2, 0); push_frame(3, 0); push_frame(0, 10);
    drive_inputs();
    drain(200);

    // Enable mask 1010: only channels 1 and 3, alternating.
    start_scn();
    ch_en = 4'b1010; src_on = '1; watch02 = 1'b1;
    for (int k = 0; k < int'(NCH); k++) lim[k] = 20;
    push_frame(1, 0); push_frame(3, 0); push_frame(1, 10); push_frame(3, 10);
    drive_inputs();
    drain(200);
    chk("rdy_0_2", 64'(bad_rdy02), 64'(0));

    // Random backpressure on channel 2.
    start_scn();
    rnd_rdy = 1'b1; src_on[2] = 1'b1; lim[2] = 30;
    push_frame(2, 0); push_frame(2, 10); push_frame(2, 20);
    drive_inputs();
    drain(2000);

    // Disable channel 1 mid-frame: frame completes, channel 1 not regranted.
    start_scn();
    src_on[1] = 1'b1; lim[1] = 20; lim[3] = 20;
    push_frame(1, 0); push_frame(3, 0); push_frame(3, 10);
    drive_inputs();
    wait_beat(1, 4);
    ch_en[1] = 1'b0; src_on[3] = 1'b1;
    drive_inputs();
    drain(300);

    // Reset for one cycle at beat 6: partial frame dropped, channel 0 first afterwards.
    start_scn();
    src_on[1] = 1'b1; lim[1] = 16; lim[0] = 10;
    for (int b = 0; b < 6; b++) begin
      exp_t e;
      e.ch = 2'd1; e.data = smp(1, b); e.last = 1'b0; e.first = (b == 0);
      q.push_back(e);
    end
    push_frame(0, 0); push_frame(1, 6);
    drive_inputs();
    wait_beat(1, 6);
    rstn = 1'b0; src_on[0] = 1'b1;
    drive_inputs();
    cyc();
    chk("midrst_mvalid", 64'(m_tvalid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_sready", 64'(s_tready), 64'(0));
    rstn = 1'b1;
    last_vld = 1'b0;
    drain(300);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
